// File: rtl/copier_if.sv
// copier_if: job request, sensor and status bundle for the copier controller
interface copier_if #(
  parameter int CNT_W  = 4,
  parameter int NTRAYS = 2,
  parameter int TS_W   = NTRAYS > 1 ? $clog2(NTRAYS) : 1
);
  logic              start;
  logic [CNT_W-1:0]  qty;
  logic [TS_W-1:0]   tray_sel;
  logic [NTRAYS-1:0] paper;
  logic              jam;
  logic              cover_open;
  logic              abort;
  logic              copy_out;
  logic              no_paper;
  logic              jammed;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  copies_done;
  logic [2:0]        state;
  modport master (
    output start, qty, tray_sel, paper, jam, cover_open, abort,
    input  copy_out, no_paper, jammed, busy, done, copies_done, state
  );
  modport slave (
    input  start, qty, tray_sel, paper, jam, cover_open, abort,
    output copy_out, no_paper, jammed, busy, done, copies_done, state
  );
endinterface

// File: rtl/copier_ctrl.sv
// copier_ctrl: copy job sequencer with paper-out, jam recovery and abort handling
module copier_ctrl #(
  parameter int CNT_W    = 4,
  parameter int NTRAYS   = 2,
  parameter int COPY_CYC = 2
) (
  input logic      clk_2,
  input logic      reset,
  copier_if.slave  bus
);
  localparam int TS_W = NTRAYS > 1 ? $clog2(NTRAYS) : 1;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRINT      = 3'd1,
    WAIT_PAPER = 3'd2,
    JAM        = 3'd3,
    CLEAR      = 3'd4,
    DONE       = 3'd5
  } state_t;
  state_t           st, nxt;
  logic [7:0]       timer, nxt_timer;
  logic [CNT_W-1:0] qty_l, nxt_qty, cnt, nxt_cnt;
  logic [TS_W-1:0]  tray_l, nxt_tray, sel;
  logic             last, has_paper;
  // out-of-range trays fall back to tray 0
  assign sel       = 32'(bus.tray_sel) < NTRAYS ? bus.tray_sel : '0;
  assign has_paper = bus.paper[tray_l];
  assign last      = timer == 8'(COPY_CYC - 1);
  assign bus.state       = st;
  assign bus.copies_done = cnt;
  // next-state rules: jam outranks abort, abort outranks normal progress
  always_comb begin
    nxt       = st;
    nxt_timer = timer;
    nxt_cnt   = cnt;
    nxt_qty   = qty_l;
    nxt_tray  = tray_l;
    case (st)
      IDLE: if (bus.start && bus.qty != '0) begin
        nxt_qty   = bus.qty;
        nxt_tray  = sel;
        nxt_cnt   = '0;
        nxt_timer = '0;
        nxt       = bus.paper[sel] ? PRINT : WAIT_PAPER;
      end
      PRINT: if (bus.jam) begin
        nxt       = JAM;
        nxt_timer = '0;
      end else if (bus.abort) begin
        nxt       = IDLE;
        nxt_timer = '0;
      end else if (last) begin
        nxt_cnt   = cnt + CNT_W'(1);
        nxt_timer = '0;
        nxt       = nxt_cnt == qty_l ? DONE : has_paper ? PRINT : WAIT_PAPER;
      end else
        nxt_timer = timer + 8'd1;
      WAIT_PAPER: if (bus.jam) begin
        nxt       = JAM;
        nxt_timer = '0;
      end else if (bus.abort)
        nxt = IDLE;
      else if (has_paper) begin
        nxt       = PRINT;
        nxt_timer = '0;
      end
      JAM: nxt = bus.cover_open && !bus.jam ? CLEAR : JAM;
      CLEAR: if (bus.jam)
        nxt = JAM;
      else if (!bus.cover_open) begin
        nxt       = has_paper ? PRINT : WAIT_PAPER;
        nxt_timer = '0;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, job context and status flags all register from the next state
  always_ff @(posedge clk_2) begin
    if (reset) begin
      st           <= IDLE;
      timer        <= '0;
      cnt          <= '0;
      qty_l        <= '0;
      tray_l       <= '0;
      bus.copy_out <= 1'b0;
      bus.no_paper <= 1'b0;
      bus.jammed   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      st           <= nxt;
      timer        <= nxt_timer;
      cnt          <= nxt_cnt;
      qty_l        <= nxt_qty;
      tray_l       <= nxt_tray;
      bus.copy_out <= nxt == PRINT;
      bus.no_paper <= nxt == WAIT_PAPER;
      bus.jammed   <= nxt == JAM || nxt == CLEAR;
      bus.busy     <= nxt != IDLE;
      bus.done     <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_copier_ctrl.sv
// tb_copier_ctrl: directed and randomized checks of copier_ctrl against a job-level model
module tb_copier_ctrl;
  localparam int CC = 2;
  logic clk_2 = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_mode, m_made, m_want, m_tray, m_left;
  int   n_co, n_done;
  always #5 clk_2 = ~clk_2;
  copier_if #(.CNT_W(4), .NTRAYS(2)) bus ();
  copier_if #(.CNT_W(4), .NTRAYS(3)) b3 ();
  copier_ctrl #(.CNT_W(4), .NTRAYS(2), .COPY_CYC(CC)) dut (.clk_2(clk_2), .reset(reset), .bus(bus));
  copier_ctrl #(.CNT_W(4), .NTRAYS(3), .COPY_CYC(1)) dut3 (.clk_2(clk_2), .reset(reset), .bus(b3));

  task automatic chk(string tag, int obs, int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // modes: 0 idle, 1 printing, 2 waiting paper, 3 jammed, 4 clearing, 5 finished
  task automatic enter_work();
    if (bus.paper[m_tray]) begin
      m_mode = 1;
      m_left = CC;
    end else
      m_mode = 2;
  endtask

  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_made = 0; m_want = 0; m_tray = 0; m_left = 0;
    end else case (m_mode)
      0: if (bus.start && bus.qty > 0) begin
        m_want = int'(bus.qty);
        m_tray = bus.tray_sel < 2 ? int'(bus.tray_sel) : 0;
        m_made = 0;
        enter_work();
      end
      1: if (bus.jam) m_mode = 3;
         else if (bus.abort) m_mode = 0;
         else begin
           m_left--;
           if (m_left == 0) begin
             m_made++;
             if (m_made == m_want) m_mode = 5;
             else enter_work();
           end
         end
      2: if (bus.jam) m_mode = 3;
         else if (bus.abort) m_mode = 0;
         else if (bus.paper[m_tray]) enter_work();
      3: if (bus.cover_open && !bus.jam) m_mode = 4;
      4: if (bus.jam) m_mode = 3;
         else if (!bus.cover_open) enter_work();
      5: m_mode = 0;
      default: m_mode = 0;
    endcase
  endtask

  task automatic tick();
    logic [11:0] obs, exp;
    @(posedge clk_2);
    model_step();
    #1;
    obs = {bus.state, bus.copy_out, bus.no_paper, bus.jammed, bus.busy, bus.done, bus.copies_done};
    exp = {3'(m_mode), m_mode == 1, m_mode == 2, m_mode == 3 || m_mode == 4, m_mode != 0, m_mode == 5, 4'(m_made)};
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL cycle t=%0t obs=%h exp=%h", $time, obs, exp);
    end
  endtask

  task automatic idle_in();
    bus.start = 0; bus.qty = 0; bus.tray_sel = 0; bus.paper = 2'b11;
    bus.jam = 0; bus.cover_open = 0; bus.abort = 0; reset = 0;
  endtask

  task automatic go(int q, int t);
    bus.start = 1; bus.qty = 4'(q); bus.tray_sel = 1'(t);
    tick();
    bus.start = 0;
  endtask

  task automatic run_to_idle(output int co, output int dn);
    co = int'(bus.copy_out);
    dn = int'(bus.done);
    for (int i = 0; i < 40; i++) begin
      if (bus.state == 3'd0) break;
      tick();
      co += int'(bus.copy_out);
      dn += int'(bus.done);
    end
    chk("reach_idle", int'(bus.state), 0);
  endtask

  initial begin
    idle_in();
    reset = 1;
    b3.start = 0; b3.qty = 0; b3.tray_sel = 0; b3.paper = 0;
    b3.jam = 0; b3.cover_open = 0; b3.abort = 0;
    tick();
    tick();
    chk("reset_state", int'(bus.state), 0);
    chk("reset_busy", int'(bus.busy), 0);
    idle_in();
    // basic run: 3 copies, 2 cycles each
    go(3, 0);
    chk("run_state", int'(bus.state), 1);
    run_to_idle(n_co, n_done);
    chk("run_copy_cycles", n_co, 6);
    chk("run_done_pulses", n_done, 1);
    chk("run_copies", int'(bus.copies_done), 3);
    tick();
    chk("run_hold_count", int'(bus.copies_done), 3);
    // paper out on tray 1
    bus.paper = 2'b01;
    go(2, 1);
    chk("po_state", int'(bus.state), 2);
    chk("po_flag", int'(bus.no_paper), 1);
    tick();
    tick();
    chk("po_still", int'(bus.state), 2);
    bus.paper = 2'b11;
    run_to_idle(n_co, n_done);
    chk("po_copies", int'(bus.copies_done), 2);
    chk("po_done", n_done, 1);
    // jam in second cycle of copy 2
    go(3, 0);
    tick(); tick(); tick();
    bus.jam = 1;
    tick();
    chk("jam_state", int'(bus.state), 3);
    chk("jam_count", int'(bus.copies_done), 1);
    chk("jam_flag", int'(bus.jammed), 1);
    chk("jam_copy_out", int'(bus.copy_out), 0);
    bus.jam = 0; bus.cover_open = 1;
    tick();
    chk("clear_state", int'(bus.state), 4);
    bus.cover_open = 0;
    tick();
    chk("resume_state", int'(bus.state), 1);
    chk("resume_jammed", int'(bus.jammed), 0);
    run_to_idle(n_co, n_done);
    chk("jam_final", int'(bus.copies_done), 3);
    // jam on completion edge of copy 1, then abort with jam
    go(3, 0);
    tick();
    bus.jam = 1;
    tick();
    chk("jam_wins_count", int'(bus.copies_done), 0);
    bus.jam = 0; bus.cover_open = 1;
    tick();
    bus.cover_open = 0;
    tick();
    bus.jam = 1; bus.abort = 1;
    tick();
    chk("abort_jam_state", int'(bus.state), 3);
    bus.jam = 0; bus.cover_open = 1;
    tick();
    chk("abort_ignored_jam", int'(bus.state), 4);
    bus.cover_open = 0; bus.abort = 0;
    tick();
    bus.abort = 1;
    tick();
    chk("abort_state", int'(bus.state), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_copy_out", int'(bus.copy_out), 0);
    bus.abort = 0;
    // qty 0 ignored
    go(0, 0);
    chk("qty0_state", int'(bus.state), 0);
    chk("qty0_busy", int'(bus.busy), 0);
    // reset in CLEAR
    go(2, 0);
    bus.jam = 1;
    tick();
    bus.jam = 0; bus.cover_open = 1;
    tick();
    chk("pre_reset_clear", int'(bus.state), 4);
    reset = 1;
    tick();
    chk("rst_clear_outs", int'({bus.state, bus.copy_out, bus.no_paper, bus.jammed, bus.busy, bus.done, bus.copies_done}), 0);
    idle_in();
    // 3-tray variant: out-of-range tray maps to tray 0, single-cycle copies
    b3.paper = 3'b001; b3.tray_sel = 2'd3; b3.qty = 4'd1; b3.start = 1;
    tick();
    b3.start = 0;
    chk("t3_badtray_print", int'(b3.state), 1);
    tick();
    chk("t3_done_state", int'(b3.state), 5);
    chk("t3_count", int'(b3.copies_done), 1);
    tick();
    chk("t3_idle", int'(b3.state), 0);
    b3.tray_sel = 2'd2; b3.start = 1;
    tick();
    b3.start = 0;
    chk("t3_tray2_wait", int'(b3.state), 2);
    b3.abort = 1;
    tick();
    b3.abort = 0;
    chk("t3_abort", int'(b3.state), 0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset          = $urandom_range(0, 99) < 2;
      bus.start      = $urandom_range(0, 99) < 30;
      bus.qty        = 4'($urandom_range(0, 4));
      bus.tray_sel   = 1'($urandom_range(0, 1));
      bus.paper      = {$urandom_range(0, 99) < 85, $urandom_range(0, 99) < 85};
      bus.jam        = $urandom_range(0, 99) < 5;
      bus.cover_open = $urandom_range(0, 99) < 40;
      bus.abort      = $urandom_range(0, 99) < 3;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
